// File: rtl/cordic_pkg.sv
// cordic_pkg: operation codes, fixed-point constants, FSM states and atan table for the CORDIC core
package cordic_pkg;
  localparam logic [1:0] OP_SINCOS = 2'd0;
  localparam logic [1:0] OP_ROTATE = 2'd1;
  localparam logic [1:0] OP_VECTOR = 2'd2;
  localparam logic [15:0] K_Q88 = 16'h009B;
  localparam logic [15:0] HALF_PI_Q313 = 16'h3244;
  typedef enum logic [1:0] {S_IDLE, S_ROT, S_DONE} state_t;
  // round(atan(2^-i) * 8192)
  localparam logic [15:0] ATAN_Q313 [16] = '{
    16'h1922, 16'h0ED6, 16'h07D7, 16'h03FB, 16'h01FF, 16'h0100, 16'h0080, 16'h0040,
    16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0000, 16'h0000
  };
endpackage

// File: rtl/cordic_iter_core_if.sv
// cordic_iter_core_if: request and result bundle between the CORDIC core and its user
interface cordic_iter_core_if #(parameter int W = 16);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [W-1:0] z_in;
  logic         busy;
  logic         done;
  logic [W-1:0] x_sin_cos;
  logic [W-1:0] y_sin_cos;
  logic [W-1:0] angle_sin_cos;
  logic [3:0]   select;
  modport master (
    output start, op, x_in, y_in, z_in,
    input  busy, done, x_sin_cos, y_sin_cos, angle_sin_cos, select
  );
  modport slave (
    input  start, op, x_in, y_in, z_in,
    output busy, done, x_sin_cos, y_sin_cos, angle_sin_cos, select
  );
endinterface

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational atan(2^-i) lookup in Q3.13
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [15:0] atan
);
  assign atan = ATAN_Q313[idx];
endmodule

// File: rtl/cordic_iter_core.sv
// cordic_iter_core: iterative CORDIC, one micro-rotation per clock, rotation or vectoring mode
// Define CORDIC_QUADRANT_EXT_EN to fold inputs by +/-pi/2 at capture for full-range convergence.
module cordic_iter_core
  import cordic_pkg::*;
#(
  parameter int ITER = 14,
  parameter int W    = 16
) (
  input logic clk,
  input logic rst,
  cordic_iter_core_if.slave bus
);
  localparam int DW = W + 2;
  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t state_q, state_d;
  logic [3:0] i_q, i_d;
  logic [1:0] op_q, op_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [W-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
  logic [3:0] sel_q, sel_d;
  logic [15:0] atan_i;
  logic signed [DW-1:0] xa, ya, za, xc, yc, zc, x_n, y_n, z_n, at;
  logic cap_vec, cap_k, vec, dpos;

  function automatic logic [W-1:0] sat(input logic signed [DW-1:0] v);
    return (v[DW-1:W-1] == {(DW-W+1){v[DW-1]}}) ? v[W-1:0] : {v[DW-1], {(W-1){~v[DW-1]}}};
  endfunction

  cordic_atan_rom u_rom (.idx(i_q), .atan(atan_i));

  assign cap_vec = bus.op == OP_VECTOR;
  assign cap_k   = !cap_vec && bus.op != OP_ROTATE;
  assign xa = cap_k ? DW'($signed(K_Q88)) : DW'($signed(bus.x_in));
  assign ya = cap_k ? '0 : DW'($signed(bus.y_in));
  assign za = DW'($signed(bus.z_in));

`ifdef CORDIC_QUADRANT_EXT_EN
  logic signed [DW-1:0] hp;
  logic rot_pos, rot_neg;
  assign hp = DW'($signed(HALF_PI_Q313));
  // vectoring picks the fold direction from the sign of y so the folded x is non-negative
  assign rot_pos = cap_vec ? (xa < 0 && ya < 0)  : (za > hp);
  assign rot_neg = cap_vec ? (xa < 0 && ya >= 0) : (za < -hp);
  assign xc = rot_pos ? -ya : rot_neg ? ya : xa;
  assign yc = rot_pos ? xa : rot_neg ? -xa : ya;
  assign zc = rot_pos ? za - hp : rot_neg ? za + hp : za;
`else
  assign xc = xa;
  assign yc = ya;
  assign zc = za;
`endif

  assign vec  = op_q == OP_VECTOR;
  assign dpos = vec ? y_q[DW-1] : !z_q[DW-1];
  assign at   = DW'(atan_i);
  assign x_n  = dpos ? x_q - (y_q >>> i_q) : x_q + (y_q >>> i_q);
  assign y_n  = dpos ? y_q + (x_q >>> i_q) : y_q - (x_q >>> i_q);
  assign z_n  = dpos ? z_q - at : z_q + at;

  always_comb begin
    state_d = state_q; i_d = i_q; op_d = op_q;
    x_d = x_q; y_d = y_q; z_d = z_q;
    busy_d = busy_q; done_d = 1'b0;
    xo_d = xo_q; yo_d = yo_q; zo_d = zo_q; sel_d = sel_q;
    if (state_q == S_IDLE && bus.start) begin
      state_d = S_ROT; busy_d = 1'b1; i_d = '0; op_d = bus.op;
      x_d = xc; y_d = yc; z_d = zc;
    end else if (state_q == S_ROT) begin
      x_d = x_n; y_d = y_n; z_d = z_n; i_d = i_q + 4'd1;
      if (i_q == LAST) begin
        state_d = S_DONE; done_d = 1'b1; i_d = '0;
        xo_d = sat(x_n); yo_d = sat(y_n); zo_d = sat(z_n);
        sel_d = vec ? 4'b1100 : (op_q == OP_ROTATE) ? 4'b0010 : 4'b0001;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE; busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; i_q <= '0; op_q <= '0;
      x_q <= '0; y_q <= '0; z_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0;
      xo_q <= '0; yo_q <= '0; zo_q <= '0; sel_q <= '0;
    end else begin
      state_q <= state_d; i_q <= i_d; op_q <= op_d;
      x_q <= x_d; y_q <= y_d; z_q <= z_d;
      busy_q <= busy_d; done_q <= done_d;
      xo_q <= xo_d; yo_q <= yo_d; zo_q <= zo_d; sel_q <= sel_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.x_sin_cos     = xo_q;
  assign bus.y_sin_cos     = yo_q;
  assign bus.angle_sin_cos = zo_q;
  assign bus.select        = sel_q;
endmodule

// File: tb/tb_cordic_iter_core.sv
// tb_cordic_iter_core: directed vectors against a real-arithmetic CORDIC model with cycle-level timing
module tb_cordic_iter_core;
  localparam int ITER = 14;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int m_left = 0;
  logic m_done = 1'b0;
  logic m_valid = 1'b0;
  logic [3:0] m_sel = 4'b0000;
  logic [3:0] p_sel = 4'b0000;
  real m_x = 0.0, m_y = 0.0, m_z = 0.0, m_tol = 0.0;
  real p_x = 0.0, p_y = 0.0, p_z = 0.0, p_tol = 0.0;

  always #5 clk = ~clk;

  cordic_iter_core_if bus ();
  cordic_iter_core #(.ITER(ITER), .W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic real clamp(input real v);
    return v > 32767.0 ? 32767.0 : v < -32768.0 ? -32768.0 : v;
  endfunction

  task automatic chk_eq(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input int act, input real exp, input real tol);
    total++;
    if (real'(act) - exp > tol || exp - real'(act) > tol) begin
      bad++;
      $display("FAIL %s: got %0d, want %0.2f within %0.2f", nm, act, exp, tol);
    end
  endtask

  // ideal result from trig: rotation by z, or polar form of (x, y), scaled by the iteration gain
  task automatic expect_op(input logic [1:0] op, input logic [15:0] xi, input logic [15:0] yi,
                           input logic [15:0] zi, output real rx, output real ry, output real rz,
                           output real tol, output logic [3:0] sel);
    real g, xr, yr, th;
    g = 1.0;
    for (int i = 0; i < ITER; i++) g = g * $sqrt(1.0 + $pow(2.0, -2.0 * i));
    xr = real'(sx(xi)) / 256.0;
    yr = real'(sx(yi)) / 256.0;
    th = real'(sx(zi)) / 8192.0;
    if (op == 2'd2) begin
      rx = g * $sqrt(xr * xr + yr * yr) * 256.0;
      ry = 0.0;
      rz = (th + $atan2(yr, xr)) * 8192.0;
      sel = 4'b1100;
    end else begin
      if (op != 2'd1) begin
        xr = 155.0 / 256.0;
        yr = 0.0;
      end
      rx = g * (xr * $cos(th) - yr * $sin(th)) * 256.0;
      ry = g * (xr * $sin(th) + yr * $cos(th)) * 256.0;
      rz = 0.0;
      sel = (op == 2'd1) ? 4'b0010 : 4'b0001;
    end
    tol = 4.0 + g * $sqrt(xr * xr + yr * yr) * 256.0 / 2048.0;
    rx = clamp(rx);
    ry = clamp(ry);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_valid = 1'b0;
      m_sel = 4'b0000;
    end else begin
      m_done = 1'b0;
      if (m_left == 0 && bus.start === 1'b1) begin
        m_left = ITER + 1;
        expect_op(bus.op, bus.x_in, bus.y_in, bus.z_in, p_x, p_y, p_z, p_tol, p_sel);
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 1) begin
          m_done = 1'b1;
          m_valid = 1'b1;
          m_x = p_x; m_y = p_y; m_z = p_z; m_tol = p_tol; m_sel = p_sel;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk_eq("done", int'(bus.done), int'(m_done));
    chk_eq("busy", int'(bus.busy), int'(m_left > 0));
    chk_eq("select", int'(bus.select), int'(m_sel));
    if (m_valid) begin
      chk_near("x", sx(bus.x_sin_cos), m_x, m_tol);
      chk_near("y", sx(bus.y_sin_cos), m_y, m_tol);
      chk_near("angle", sx(bus.angle_sin_cos), m_z, 8.0);
    end else begin
      chk_eq("x idle", sx(bus.x_sin_cos), 0);
      chk_eq("y idle", sx(bus.y_sin_cos), 0);
      chk_eq("angle idle", sx(bus.angle_sin_cos), 0);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.x_in = x; bus.y_in = y; bus.z_in = z;
    @(negedge clk);
    bus.start = 1'b0; bus.x_in = 16'h5A5A; bus.y_in = 16'hA5A5; bus.z_in = 16'h1234;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk_eq("latency", lat, ITER + 1);
  endtask

  initial begin
    int dn, t2;
    bus.start = 1'b0; bus.op = 2'd0; bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;
    repeat (3) @(negedge clk);
    chk_eq("reset busy", int'(bus.busy), 0);
    chk_eq("reset select", int'(bus.select), 0);
    chk_eq("reset x", sx(bus.x_sin_cos), 0);
    rst = 1'b0;
    run_op(2'd0, 16'h0000, 16'h0000, 16'h0000);
    chk_near("cos0 x", sx(bus.x_sin_cos), 256.0, 2.0);
    chk_near("cos0 y", sx(bus.y_sin_cos), 0.0, 2.0);
    chk_eq("cos0 select", int'(bus.select), 1);
    run_op(2'd0, 16'h0000, 16'h0000, 16'h10C1);
    chk_near("pi6 x", sx(bus.x_sin_cos), 222.0, 2.0);
    chk_near("pi6 y", sx(bus.y_sin_cos), 128.0, 2.0);
    chk_near("pi6 angle", sx(bus.angle_sin_cos), 0.0, 8.0);
    run_op(2'd2, 16'h0100, 16'h0100, 16'h0000);
    chk_near("vec45 angle", sx(bus.angle_sin_cos), 6434.0, 4.0);
    chk_near("vec45 mag", sx(bus.x_sin_cos), 596.0, 3.0);
    chk_eq("vec45 select", int'(bus.select), 12);
    run_op(2'd1, 16'h0100, 16'h0000, 16'h1922);
    run_op(2'd1, 16'h0080, 16'h0040, 16'hF000);
    run_op(2'd2, 16'h0300, 16'hFE00, 16'h0000);
    run_op(2'd3, 16'h0000, 16'h0000, 16'hEF3F);
    chk_eq("op3 select", int'(bus.select), 1);
    run_op(2'd1, 16'h7000, 16'h7000, 16'h1922);
    chk_eq("sat pos y", int'(bus.y_sin_cos), 32'h7FFF);
    run_op(2'd1, 16'h9000, 16'h9000, 16'h1922);
    chk_eq("sat neg y", int'(bus.y_sin_cos), 32'h8000);
`ifdef CORDIC_QUADRANT_EXT_EN
    run_op(2'd0, 16'h0000, 16'h0000, 16'h6488);
    chk_near("pi x", sx(bus.x_sin_cos), -256.0, 3.0);
    chk_near("pi y", sx(bus.y_sin_cos), 0.0, 3.0);
`endif
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.x_in = '0; bus.y_in = '0; bus.z_in = 16'h10C1;
    dn = 0;
    t2 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dn++;
        if (dn == 1) begin
          chk_eq("b2b first done cycle", k, 15);
          chk_near("b2b first x", sx(bus.x_sin_cos), 222.0, 2.0);
          chk_near("b2b first y", sx(bus.y_sin_cos), 128.0, 2.0);
        end else t2 = k;
      end
      if (k < 16) begin
        bus.op = 2'd2; bus.x_in = 16'(k * 100); bus.z_in = 16'(k * 997);
      end else if (k == 16) begin
        bus.op = 2'd0; bus.z_in = 16'h0000;
      end else bus.start = 1'b0;
    end
    chk_eq("b2b done count", dn, 2);
    chk_eq("b2b second done cycle", t2, 31);
    chk_near("b2b second x", sx(bus.x_sin_cos), 256.0, 2.0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.z_in = 16'h10C1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_eq("rst busy", int'(bus.busy), 0);
    chk_eq("rst done", int'(bus.done), 0);
    chk_eq("rst x", sx(bus.x_sin_cos), 0);
    chk_eq("rst y", sx(bus.y_sin_cos), 0);
    chk_eq("rst angle", sx(bus.angle_sin_cos), 0);
    chk_eq("rst select", int'(bus.select), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk_eq("done after rst", dn, 0);
    run_op(2'd0, 16'h0000, 16'h0000, 16'h0000);
    chk_near("post rst x", sx(bus.x_sin_cos), 256.0, 2.0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
